alu_share_arbiter: RTL and testbench



---
 rtl/alu_share_arbiter_pkg.sv | 22 ++
 rtl/alu_share_arbiter_rr_pick2.sv | 23 ++
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// rtl/alu_share_arbiter_pkg.sv - shared state encoding and ALU select codes
package alu_share_arbiter_pkg;

  // Arbiter sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // ALU function-select codes understood by the shared ALU
  localparam logic [2:0] ALU_SEL_FWD = 3'b000;
  localparam logic [2:0] ALU_SEL_ADD = 3'b001;
  localparam logic [2:0] ALU_SEL_AND = 3'b010;
  localparam logic [2:0] ALU_SEL_OR  = 3'b011;

  // Port index that is not the given one; used to alternate on ties
  function automatic logic other_port(input logic port);
    return ~port;
  endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick2.sv
// rtl/alu_share_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module alu_share_arbiter_rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  import alu_share_arbiter_pkg::*;

  // A lone requester wins outright; on a tie the port not served last wins
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = other_port(last_grant);
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int DATA_W      = 8,
  parameter int SEL_W       = 3,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] OPA0,
  input  logic [DATA_W-1:0] OPB0,
  input  logic [SEL_W-1:0]  SEL0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] OPA1,
  input  logic [DATA_W-1:0] OPB1,
  input  logic [SEL_W-1:0]  SEL1,
  output logic              ACK0,
  output logic              ACK1,
  output logic [DATA_W-1:0] RESULT,
  output logic              BUSY,
  output logic [DATA_W-1:0] ALU_DATA1,
  output logic [DATA_W-1:0] ALU_DATA2,
  output logic [SEL_W-1:0]  ALU_SELECT,
  input  logic [DATA_W-1:0] ALU_RESULT
);

  import alu_share_arbiter_pkg::*;

  // Counter only needs to hold EXEC_CYCLES-1; keep at least one bit
  localparam int CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_id_q, gnt_id_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] alu_data1_q, alu_data1_d;
  logic [DATA_W-1:0] alu_data2_q, alu_data2_d;
  logic [SEL_W-1:0]  alu_select_q, alu_select_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              busy_q, busy_d;

  logic              pick_valid;
  logic              pick_winner;

  alu_share_arbiter_rr_pick2 u_pick (
    .req0       (REQ0),
    .req1       (REQ1),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // Next-state logic: grant in IDLE, count settle cycles in EXEC, pulse ACK in DONE
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_id_d     = gnt_id_q;
    last_grant_d = last_grant_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_select_d = alu_select_q;
    result_d     = result_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d      = ST_EXEC;
          gnt_id_d     = pick_winner;
          last_grant_d = pick_winner;
          alu_data1_d  = pick_winner ? OPA1 : OPA0;
          alu_data2_d  = pick_winner ? OPB1 : OPB0;
          alu_select_d = pick_winner ? SEL1 : SEL0;
          cnt_d        = CNT_INIT;
          busy_d       = 1'b1;
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          result_d = ALU_RESULT;
          state_d  = ST_DONE;
          ack0_d   = ~gnt_id_q;
          ack1_d   = gnt_id_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset drops any operation in flight without an ACK
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      gnt_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_select_q <= '0;
      result_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_id_q     <= gnt_id_d;
      last_grant_q <= last_grant_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_select_q <= alu_select_d;
      result_q     <= result_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
    end
  end

  assign ACK0       = ack0_q;
  assign ACK1       = ack1_q;
  assign RESULT     = result_q;
  assign BUSY       = busy_q;
  assign ALU_DATA1  = alu_data1_q;
  assign ALU_DATA2  = alu_data2_q;
  assign ALU_SELECT = alu_select_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: EXEC_CYCLES = 1
  logic       a_req0, a_req1, a_ack0, a_ack1, a_busy;
  logic [7:0] a_opa0, a_opb0, a_opa1, a_opb1, a_result, a_d1, a_d2, a_alu_res;
  logic [2:0] a_sel0, a_sel1, a_alu_sel;

  // Instance B: EXEC_CYCLES = 3
  logic       b_req0, b_req1, b_ack0, b_ack1, b_busy;
  logic [7:0] b_opa0, b_opb0, b_opa1, b_opb1, b_result, b_d1, b_d2, b_alu_res;
  logic [2:0] b_sel0, b_sel1, b_alu_sel;

  int checks = 0;
  int errors = 0;

  // Stand-in for the shared combinational ALU
  function automatic logic [7:0] alu_model(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      ALU_SEL_FWD: return x;
      ALU_SEL_ADD: return x + y;
      ALU_SEL_AND: return x & y;
      ALU_SEL_OR:  return x | y;
      default:     return 8'h00;
    endcase
  endfunction

  assign a_alu_res = alu_model(a_alu_sel, a_d1, a_d2);
  assign b_alu_res = alu_model(b_alu_sel, b_d1, b_d2);

  alu_share_arbiter #(.DATA_W(8), .SEL_W(3), .EXEC_CYCLES(1)) u_dut_a (
    .CLK(clk), .RESET(rst),
    .REQ0(a_req0), .OPA0(a_opa0), .OPB0(a_opb0), .SEL0(a_sel0),
    .REQ1(a_req1), .OPA1(a_opa1), .OPB1(a_opb1), .SEL1(a_sel1),
    .ACK0(a_ack0), .ACK1(a_ack1), .RESULT(a_result), .BUSY(a_busy),
    .ALU_DATA1(a_d1), .ALU_DATA2(a_d2), .ALU_SELECT(a_alu_sel), .ALU_RESULT(a_alu_res)
  );

  alu_share_arbiter #(.DATA_W(8), .SEL_W(3), .EXEC_CYCLES(3)) u_dut_b (
    .CLK(clk), .RESET(rst),
    .REQ0(b_req0), .OPA0(b_opa0), .OPB0(b_opb0), .SEL0(b_sel0),
    .REQ1(b_req1), .OPA1(b_opa1), .OPB1(b_opb1), .SEL1(b_sel1),
    .ACK0(b_ack0), .ACK1(b_ack1), .RESULT(b_result), .BUSY(b_busy),
    .ALU_DATA1(b_d1), .ALU_DATA2(b_d2), .ALU_SELECT(b_alu_sel), .ALU_RESULT(b_alu_res)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_a_port(input bit p, input logic req, input logic [7:0] x, input logic [7:0] y, input logic [2:0] s);
    if (!p) begin
      a_req0 = req; a_opa0 = x; a_opb0 = y; a_sel0 = s;
    end else begin
      a_req1 = req; a_opa1 = x; a_opb1 = y; a_sel1 = s;
    end
  endtask

  // One transaction on instance A; optionally corrupt OPA in the cycle after grant
  task automatic txn_a(input string tag, input bit p, input logic [7:0] x, input logic [7:0] y,
                       input logic [2:0] s, input logic [7:0] exp, input bit change_opa);
    int  k;
    bit  got;
    bit  other_seen;
    k = 0; got = 0; other_seen = 0;
    @(negedge clk);
    set_a_port(p, 1'b1, x, y, s);
    while (!got && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (k == 1 && change_opa) begin
        if (!p) a_opa0 = 8'hFF; else a_opa1 = 8'hFF;
      end
      if ((p ? a_ack1 : a_ack0) === 1'b1) got = 1;
      if ((p ? a_ack0 : a_ack1) === 1'b1) other_seen = 1;
    end
    check({tag, "_ack_seen"}, got, 1);
    check({tag, "_latency"}, k, 2);
    check({tag, "_result"}, a_result, exp);
    check({tag, "_other_ack"}, other_seen, 0);
    if (change_opa) check({tag, "_alu_data1_held"}, a_d1, x);
    set_a_port(p, 1'b0, 8'h00, 8'h00, 3'b000);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_ack_pulse_one_cycle"}, {a_ack0, a_ack1}, 2'b00);
    check({tag, "_busy_after"}, a_busy, 0);
    check({tag, "_result_held"}, a_result, exp);
  endtask

  initial begin
    int n;
    int k;
    bit both;
    int acks [4];
    logic [7:0] res [4];
    int when [4];
    int busy_cnt;
    bit b_got;
    bit b_stable;

    rst = 1'b1;
    a_req0 = 0; a_opa0 = 0; a_opb0 = 0; a_sel0 = 0;
    a_req1 = 0; a_opa1 = 0; a_opb1 = 0; a_sel1 = 0;
    b_req0 = 0; b_opa0 = 0; b_opb0 = 0; b_sel0 = 0;
    b_req1 = 0; b_opa1 = 0; b_opb1 = 0; b_sel1 = 0;

    // Power-on reset state
    repeat (2) @(negedge clk);
    check("rst_a_outputs", {a_ack0, a_ack1, a_busy, a_result, a_d1, a_d2, a_alu_sel}, '0);
    check("rst_b_outputs", {b_ack0, b_ack1, b_busy, b_result, b_d1, b_d2, b_alu_sel}, '0);
    rst = 1'b0;

    // Reset in the middle of a port-0 EXEC aborts it without an ACK
    @(negedge clk);
    set_a_port(0, 1'b1, 8'hF0, 8'h3C, ALU_SEL_AND);
    @(posedge clk);
    @(negedge clk);
    check("midrst_busy_before", a_busy, 1);
    check("midrst_d1_latched", a_d1, 8'hF0);
    rst = 1'b1;
    set_a_port(0, 1'b0, 8'h00, 8'h00, 3'b000);
    @(posedge clk);
    @(negedge clk);
    check("midrst_no_ack_1", {a_ack0, a_ack1}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    check("midrst_no_ack_2", {a_ack0, a_ack1}, 2'b00);
    check("midrst_outputs_zero", {a_busy, a_result, a_d1, a_d2, a_alu_sel}, '0);
    rst = 1'b0;

    // Contention: both held high, first grant must go to port 0 after reset
    @(negedge clk);
    set_a_port(0, 1'b1, 8'h0F, 8'hA0, ALU_SEL_OR);
    set_a_port(1, 1'b1, 8'h5A, 8'h00, ALU_SEL_FWD);
    n = 0; k = 0; both = 0;
    for (int i = 0; i < 4; i++) begin
      acks[i] = -1; res[i] = 8'h00; when[i] = 0;
    end
    while (n < 4 && k < 40) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (a_ack0 && a_ack1) both = 1;
      if (a_ack0 || a_ack1) begin
        acks[n] = a_ack1 ? 1 : 0;
        res[n]  = a_result;
        when[n] = k;
        n++;
      end
    end
    set_a_port(0, 1'b0, 8'h00, 8'h00, 3'b000);
    set_a_port(1, 1'b0, 8'h00, 8'h00, 3'b000);
    check("cont_ack_count", n, 4);
    check("cont_never_both", both, 0);
    check("cont_first_latency", when[0], 2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cont_order_%0d", i), acks[i], i % 2);
      check($sformatf("cont_result_%0d", i), res[i], (i % 2) ? 8'h5A : 8'hAF);
    end
    for (int i = 1; i < 4; i++) begin
      check($sformatf("cont_spacing_%0d", i), when[i] - when[i-1], 3);
    end
    @(posedge clk);

    // Single transactions on instance A
    txn_a("and0", 0, 8'hF0, 8'h3C, ALU_SEL_AND, 8'h30, 0);
    txn_a("addwrap1", 1, 8'h05, 8'hFB, ALU_SEL_ADD, 8'h00, 0);
    txn_a("opchg0", 0, 8'h12, 8'h00, ALU_SEL_FWD, 8'h12, 1);

    // Instance B with three settle cycles
    @(negedge clk);
    b_req0 = 1; b_opa0 = 8'h10; b_opb0 = 8'h01; b_sel0 = ALU_SEL_ADD;
    k = 0; busy_cnt = 0; b_got = 0; b_stable = 1;
    while (!b_got && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (b_busy) busy_cnt++;
      if (b_busy && !b_ack0 && (b_d1 !== 8'h10 || b_d2 !== 8'h01)) b_stable = 0;
      if (b_ack0) b_got = 1;
    end
    b_req0 = 0;
    check("exec3_ack_seen", b_got, 1);
    check("exec3_latency", k, 4);
    check("exec3_result", b_result, 8'h11);
    check("exec3_operands_stable", b_stable, 1);
    check("exec3_no_ack1", b_ack1, 0);
    @(posedge clk);
    @(negedge clk);
    if (b_busy) busy_cnt++;
    check("exec3_busy_cycles", busy_cnt, 4);
    check("exec3_ack_cleared", b_ack0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
